// File: rtl/alu_seq_driver.sv
// Sequencer/checker for a 4-bit combinational ALU: accepts requests, drives the ALU from
// registers, captures its response a cycle later and scores it against a reference model.
module alu_seq_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_equal,
    input  logic             alu_even,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_equal,
    output logic             out_even,
    output logic             out_mismatch,
    input  logic             clr_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_equal_q, out_equal_d;
    logic             out_even_q, out_even_d;
    logic             out_mismatch_q, out_mismatch_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] exp_out;
    logic             exp_equal;
    logic             exp_even;
    logic             resp_mismatch;

    // Reference model works from the latched operands, which stay put until the next accept.
    always_comb begin
        exp_out = '0;
        unique case (alu_op_q)
            2'b00: exp_out = alu_a_q + alu_b_q;
            2'b01: exp_out = alu_a_q & alu_b_q;
            2'b10: exp_out = alu_a_q | alu_b_q;
            2'b11: exp_out = alu_a_q ^ alu_b_q;
        endcase
        exp_equal     = (alu_a_q == alu_b_q);
        exp_even      = ~exp_out[0];
        resp_mismatch = (alu_out != exp_out) || (alu_equal != exp_equal)
                        || (alu_even != exp_even);
    end

    always_comb begin
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        out_result_d   = out_result_q;
        out_equal_d    = out_equal_q;
        out_even_d     = out_even_q;
        out_mismatch_d = out_mismatch_q;
        err_sticky_d   = err_sticky_q;
        op_count_d     = op_count_q;
        err_count_d    = err_count_q;

        // Clear first so a mismatch captured on the same edge overrides it.
        if (clr_err) begin
            err_sticky_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    alu_a_d  = in_a;
                    alu_b_d  = in_b;
                    alu_op_d = in_op;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                out_result_d   = alu_out;
                out_equal_d    = alu_equal;
                out_even_d     = alu_even;
                out_mismatch_d = resp_mismatch;
                if (resp_mismatch) begin
                    err_sticky_d = 1'b1;
                end
                state_d = StResp;
            end
            StResp: begin
                if (out_ready) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    if (out_mismatch_q && (err_count_q != {CNT_W{1'b1}})) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StResp);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            out_result_q   <= '0;
            out_equal_q    <= 1'b0;
            out_even_q     <= 1'b0;
            out_mismatch_q <= 1'b0;
            err_sticky_q   <= 1'b0;
            op_count_q     <= '0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            out_result_q   <= out_result_d;
            out_equal_q    <= out_equal_d;
            out_even_q     <= out_even_d;
            out_mismatch_q <= out_mismatch_d;
            err_sticky_q   <= err_sticky_d;
            op_count_q     <= op_count_d;
            err_count_q    <= err_count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign out_result   = out_result_q;
    assign out_equal    = out_equal_q;
    assign out_even     = out_even_q;
    assign out_mismatch = out_mismatch_q;
    assign err_sticky   = err_sticky_q;
    assign op_count     = op_count_q;
    assign err_count    = err_count_q;

endmodule
